// File: rtl/mealy_win_pkg.sv
// Shared types for the mealy windowed hit statistics stage.
// MEALY_WIN_GAP_EN adds the minimum hit gap field to the report payload.
package mealy_win_pkg;

    localparam int unsigned WIN_IDX_W = 8;
    // Count fields travel at this width; narrower counters are zero-extended into it.
    localparam int unsigned RPT_CNT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } win_state_e;

    typedef struct packed {
        logic [RPT_CNT_W-1:0] hits;
        logic [WIN_IDX_W-1:0] win_idx;
        logic                 lost;
`ifdef MEALY_WIN_GAP_EN
        logic [RPT_CNT_W-1:0] min_gap;
`endif
    } win_rpt_t;

endpackage

// File: rtl/mealy_win_report.sv
// Report holding register with valid/ready handshake and sticky loss flag.
// MEALY_WIN_GAP_EN adds the rpt_min_gap field.
module mealy_win_report
    import mealy_win_pkg::*;
#(
    parameter int unsigned CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  win_rpt_t             rpt_d,
    input  logic                 rpt_ready,
    output logic                 rpt_valid,
    output logic [CNT_W-1:0]     rpt_hits,
    output logic [WIN_IDX_W-1:0] rpt_win_idx,
    output logic                 rpt_lost
`ifdef MEALY_WIN_GAP_EN
    ,
    output logic [CNT_W-1:0]     rpt_min_gap
`endif
);

    logic             lost_pend;
    logic             can_load_c;
    logic [CNT_W-1:0] hits_sat_c;

    // A new report may load when the slot is empty or is being drained this edge.
    assign can_load_c = !rpt_valid || rpt_ready;
    assign hits_sat_c = (|(rpt_d.hits >> CNT_W)) ? '1 : rpt_d.hits[CNT_W-1:0];

`ifdef MEALY_WIN_GAP_EN
    logic [CNT_W-1:0] gap_sat_c;
    assign gap_sat_c = (|(rpt_d.min_gap >> CNT_W)) ? '1 : rpt_d.min_gap[CNT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_valid   <= 1'b0;
            rpt_hits    <= '0;
            rpt_win_idx <= '0;
            rpt_lost    <= 1'b0;
            lost_pend   <= 1'b0;
`ifdef MEALY_WIN_GAP_EN
            rpt_min_gap <= '0;
`endif
        end else if (load && can_load_c) begin
            rpt_valid   <= 1'b1;
            rpt_hits    <= hits_sat_c;
            rpt_win_idx <= rpt_d.win_idx;
            rpt_lost    <= rpt_d.lost | lost_pend;
            lost_pend   <= 1'b0;
`ifdef MEALY_WIN_GAP_EN
            rpt_min_gap <= gap_sat_c;
`endif
        end else if (load) begin
            lost_pend <= 1'b1;
        end else if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mealy_win_stat.sv
// Windowed hit statistics downstream of the mealy detector: FSM, sample/hit counters.
// MEALY_WIN_GAP_EN adds minimum hit-gap tracking and the rpt_min_gap port.
module mealy_win_stat
    import mealy_win_pkg::*;
#(
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 k,
    input  logic                 k_en,
    output logic                 busy,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [CNT_W-1:0]     rpt_hits,
    output logic [WIN_IDX_W-1:0] rpt_win_idx,
    output logic                 rpt_lost
`ifdef MEALY_WIN_GAP_EN
    ,
    output logic [CNT_W-1:0]     rpt_min_gap
`endif
);

    localparam int unsigned      SMP_W    = $clog2(WIN_LEN);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN - 1);

    if (WIN_LEN < 2 || CNT_W < $clog2(WIN_LEN + 1) || CNT_W > RPT_CNT_W) begin : g_bad_cfg
        $error("mealy_win_stat: illegal WIN_LEN/CNT_W combination");
    end

    win_state_e           state;
    logic [SMP_W-1:0]     smp_cnt;
    logic [CNT_W-1:0]     hit_cnt;
    logic [WIN_IDX_W-1:0] win_idx;
    logic                 win_end_c;
    logic [CNT_W-1:0]     hit_sum_c;
    win_rpt_t             rpt_d_c;

    // stop outranks a coinciding window end, so the window is discarded.
    assign win_end_c = (state == RUN) && !stop && k_en && (smp_cnt == SMP_LAST);
    assign hit_sum_c = (k && (hit_cnt != '1)) ? hit_cnt + CNT_W'(1) : hit_cnt;

`ifdef MEALY_WIN_GAP_EN
    logic [CNT_W-1:0] since_cnt;
    logic [CNT_W-1:0] min_gap;
    logic             seen_hit;
    logic [CNT_W-1:0] min_nxt_c;

    // Minimum including the current sample, so the window-end sample is counted.
    assign min_nxt_c = (k && seen_hit && (since_cnt < min_gap)) ? since_cnt : min_gap;
`endif

    always_comb begin
        rpt_d_c         = '0;
        rpt_d_c.hits    = RPT_CNT_W'(hit_sum_c);
        rpt_d_c.win_idx = win_idx;
        rpt_d_c.lost    = 1'b0;
`ifdef MEALY_WIN_GAP_EN
        rpt_d_c.min_gap = RPT_CNT_W'(min_nxt_c);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            smp_cnt <= '0;
            hit_cnt <= '0;
            win_idx <= '0;
`ifdef MEALY_WIN_GAP_EN
            since_cnt <= '0;
            min_gap   <= '1;
            seen_hit  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        smp_cnt <= '0;
                        hit_cnt <= '0;
                        win_idx <= '0;
`ifdef MEALY_WIN_GAP_EN
                        since_cnt <= '0;
                        min_gap   <= '1;
                        seen_hit  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (win_end_c) begin
                        smp_cnt <= '0;
                        hit_cnt <= '0;
                        win_idx <= win_idx + WIN_IDX_W'(1);
`ifdef MEALY_WIN_GAP_EN
                        since_cnt <= '0;
                        min_gap   <= '1;
                        seen_hit  <= 1'b0;
`endif
                    end else if (k_en) begin
                        smp_cnt <= smp_cnt + SMP_W'(1);
                        hit_cnt <= hit_sum_c;
`ifdef MEALY_WIN_GAP_EN
                        if (k) begin
                            since_cnt <= CNT_W'(1);
                            seen_hit  <= 1'b1;
                            min_gap   <= min_nxt_c;
                        end else if (since_cnt != '1) begin
                            since_cnt <= since_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
            endcase
        end
    end

    mealy_win_report #(
        .CNT_W(CNT_W)
    ) u_report (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (win_end_c),
        .rpt_d       (rpt_d_c),
        .rpt_ready   (rpt_ready),
        .rpt_valid   (rpt_valid),
        .rpt_hits    (rpt_hits),
        .rpt_win_idx (rpt_win_idx),
        .rpt_lost    (rpt_lost)
`ifdef MEALY_WIN_GAP_EN
        ,
        .rpt_min_gap (rpt_min_gap)
`endif
    );

endmodule

// File: doc/mealy_win_stat.md
# mealy_win_stat

Windowed hit statistics stage placed directly downstream of the `mealy` sequence detector. It samples the detector's `k` pulse once per qualified clock and counts hits over fixed windows of `WIN_LEN` qualified samples. At the end of each window it hands a report to the consumer over a valid/ready handshake. Counting continues back-to-back while a report is pending, and dropped reports are flagged rather than stalling the detector.

## Interface
- `WIN_LEN`, default 256: qualified samples per window; must be ≥ 2.
- `CNT_W`, default 9: width of the hit count; must satisfy `CNT_W ≥ clog2(WIN_LEN+1)`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: single-cycle pulse that begins windowing.
- `stop` in 1: single-cycle pulse that aborts windowing.
- `k` in 1: detector output (`mealy.k`).
- `k_en` in 1: sample qualifier; a cycle counts only when it is high.
- `busy` out 1: high while in RUN.
- `rpt_valid` out 1: report available.
- `rpt_ready` in 1: consumer accepts the report.
- `rpt_hits` out `CNT_W`: hits in the reported window.
- `rpt_win_idx` out 8: window sequence number; wraps at 256.
- `rpt_lost` out 1: one or more reports were dropped since the previous accepted one.
- `rpt_min_gap` out `CNT_W`: present only with `MEALY_WIN_GAP_EN`.

## Operation
- States are IDLE and RUN.
  - IDLE → RUN on `start`. On this transition the sample counter, hit counter and window index are cleared.
  - RUN → IDLE on `stop`. The partial window is discarded and no report is produced.
  - `start` is ignored in RUN. `stop` is ignored in IDLE.
- A sample cycle is a clock edge in RUN with `k_en=1`. It increments the sample counter and adds `k` to the hit counter.
- Window end is the sample cycle where the sample counter equals `WIN_LEN-1`.
  - Final hits = hit_cnt + `k`.
  - The counters restart from 0 on the next edge, so there is no dead cycle between windows.
  - The window index increments for every completed window, whether or not its report is dropped.
- Report load at window end:
  - If `rpt_valid=0`, or `rpt_valid=1` and `rpt_ready=1` in the same cycle, the report registers load the new window and `rpt_valid` is 1 on the next cycle.
  - `rpt_lost` takes the value of the pending-loss flag, which is then cleared.
  - Otherwise the held report stays untouched, the new report is dropped, and the pending-loss flag is set (sticky).
- Handshake:
  - The transfer happens on an edge where `rpt_valid` and `rpt_ready` are both 1.
  - The report outputs are stable while `rpt_valid` is 1 and `rpt_ready` is 0.
  - `rpt_valid` clears after acceptance unless a new report loads on the same edge.
- `stop` does not clear a pending report; it remains deliverable in IDLE.
- The hit count saturates at its all-ones value. This is unreachable when `CNT_W` is legal.

## Timing
- Reset values are 0 for `busy`, `rpt_valid`, `rpt_hits`, `rpt_win_idx`, `rpt_lost` and `rpt_min_gap`; the state is IDLE and the pending-loss flag is 0.
- `rst_n` low mid-window or with a report pending clears everything on the next edge.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `stop` is sampled.
- Latency: `rpt_valid` rises one cycle after the window-end sample edge.
- If `stop` and a window-end sample occur on the same edge, `stop` wins and the window is discarded.
- If `start` and `stop` are both high in IDLE, `start` is taken.

## Configuration
- Macro: `MEALY_WIN_GAP_EN`.
- Defined: the block tracks the minimum distance, in qualified samples, between consecutive hits within a window.
  - It is reported on `rpt_min_gap` together with the other report fields.
  - With fewer than 2 hits in the window, `rpt_min_gap` is all-ones.
  - Hits on consecutive samples give a gap of 1.
- Undefined: the port, the gap counter and the minimum register are absent. All other behaviour is identical.

## Structure
- Package `mealy_win_pkg` holds:
  - the state enum (IDLE, RUN);
  - `WIN_IDX_W = 8`;
  - the report struct (hits, win_idx, lost, min_gap).
- Sub-module `mealy_win_report`: the report holding register, the valid/ready logic and the sticky loss flag. The top level contains the FSM and the counters.

## Test plan
- Reset: hold `rst_n=0` for 5 cycles with `k=1` and `k_en=1`. All outputs must be 0 and `busy=0`.
- Basic window: `WIN_LEN=8`, `start`, `k_en=1`, `k` = 1,0,1,1,0,0,0,1, `rpt_ready=1`. Required: `rpt_valid` high one cycle after the 8th sample, `rpt_hits=4`, `rpt_win_idx=0`, `rpt_lost=0`.
- Qualifier gaps: `WIN_LEN=8`, `k=1` constant, `k_en` toggling every cycle. Required: the window closes after 16 cycles with `rpt_hits=8`.
- Backpressure: `rpt_ready=0` across windows 0–2. Required: the window-0 report is held stable and windows 1 and 2 are dropped. Then `ready=1`; the next loaded report is `rpt_win_idx=3` with `rpt_lost=1`, and the report after it has `rpt_lost=0`.
- Abort and restart: `stop` after 5 samples. Required: no report and `busy=0` next cycle. A following `start` produces its first report with `rpt_win_idx=0`.
- Gap (macro defined): hits at qualified samples 1, 4 and 6 of an 8-sample window. Required: `rpt_min_gap=2`. A window with a single hit must report `rpt_min_gap=9'h1FF`.
